// File: rtl/if_stage.sv
// Instruction fetch stage: program counter, combinational instruction memory
// address, and the IF/ID pipeline register with stall, flush and redirect handling.
// Optional feature macro: IF_MISALIGN_CHECK_EN (aligns redirect targets and flags
// misaligned ones on misalign_o).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        misalign_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Force word alignment of the target; the flag records that we had to.
    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    assign misalign_d   = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    // Misalign flag register: one-cycle pulse after an offending redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign redirect_tgt = redirect_pc_i;
    assign misalign_o   = 1'b0;
`endif

    // Next-state selection: redirect > flush > stall > normal fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect_i) begin
            pc_d         = redirect_tgt;
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (flush_i) begin
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            // A concurrent stall still freezes the PC.
            if (!stall_i) begin
                pc_d = pc_plus4;
            end
        end else if (!stall_i) begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_instr_i;
            ifid_valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset to the bubble state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized control traffic,
// all checked against a per-edge behavioural model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_mis;

    if_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_instr_i (imem_instr_i),
        .pc_o         (pc_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_valid_o (ifid_valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // Word-addressed memory: test-plan preload, otherwise a distinct hashed word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        case (w)
            32'd0:   return 32'h00a0_0093;
            32'd1:   return 32'h0050_8113;
            32'd2:   return 32'h4051_0133;
            32'd11:  return 32'h0000_0013;
            default: return w * 32'h9E37_79B1 + 32'h0123_4567;
        endcase
    endfunction

    always_comb imem_instr_i = mem_word(imem_addr_o);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".pc"}, pc_o, m_pc);
        check_val({tag, ".addr"}, imem_addr_o, m_pc);
        check_val({tag, ".ifid_pc"}, ifid_pc_o, m_ipc);
        check_val({tag, ".ifid_pc4"}, ifid_pc4_o, m_ipc4);
        check_val({tag, ".instr"}, ifid_instr_o, m_instr);
        check_val({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
        check_val({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
    endtask

    // Model of one rising edge, applying the stage's priority rules directly.
    task automatic model_edge(input logic r, input logic s, input logic f, input logic rd,
                              input logic [31:0] rpc);
        logic [31:0] fetched;
        fetched = mem_word(m_pc);
        m_mis   = 1'b0;
        if (r) begin
            m_pc = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_valid = 1'b0;
        end else if (rd) begin
`ifdef IF_MISALIGN_CHECK_EN
            m_pc  = rpc - {30'd0, rpc[1:0]};
            m_mis = (rpc % 4) != 0;
`else
            m_pc  = rpc;
`endif
            m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_valid = 1'b0;
        end else if (f) begin
            m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_valid = 1'b0;
            if (!s) m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = fetched;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    // Drive one cycle of controls, advance DUT and model, then compare.
    task automatic cyc(input string tag, input logic r, input logic s, input logic f,
                       input logic rd, input logic [31:0] rpc);
        rst_i = r; stall_i = s; flush_i = f; redirect_i = rd; redirect_pc_i = rpc;
        model_edge(r, s, f, rd, rpc);
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_pc = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_valid = 1'b0;
        m_mis = 1'b0;

        // Reset for two cycles.
        cyc("rst0", 1, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0);
        check_val("rst_instr_const", ifid_instr_o, 32'h0000_0013);

        // First fetches after release.
        cyc("run1", 0, 0, 0, 0, 0);
        check_val("first_word", ifid_instr_o, 32'h00a0_0093);
        check_val("first_pc4", ifid_pc4_o, 32'd4);
        cyc("run2", 0, 0, 0, 0, 0);
        check_val("second_word", ifid_instr_o, 32'h0050_8113);

        // Stall three cycles at pc 8.
        for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, 0, 0);
        check_val("stall_pc", pc_o, 32'd8);
        cyc("unstall", 0, 0, 0, 0, 0);
        check_val("unstall_word", ifid_instr_o, 32'h4051_0133);
        check_val("unstall_pc", ifid_pc_o, 32'd8);

        // Redirect to 0x2C.
        cyc("redir", 0, 0, 0, 1, 32'h2C);
        check_val("redir_pc", pc_o, 32'h2C);
        check_val("redir_bubble", {31'd0, ifid_valid_o}, 32'd0);
        cyc("redir_tgt", 0, 0, 0, 0, 0);
        check_val("redir_tgt_pc", ifid_pc_o, 32'h2C);

        // Redirect + stall, then flush + stall at pc 8.
        cyc("redir_stall", 0, 1, 0, 1, 32'h2C);
        check_val("redir_stall_pc", pc_o, 32'h2C);
        cyc("to8", 0, 0, 0, 1, 32'h8);
        cyc("run8", 0, 0, 1, 0, 0);
        cyc("to8b", 0, 0, 0, 1, 32'h8);
        cyc("flush_stall", 0, 1, 1, 0, 0);
        check_val("flush_stall_pc", pc_o, 32'h8);
        check_val("flush_stall_instr", ifid_instr_o, 32'h0000_0013);

        // PC wrap.
        cyc("wrap_r", 0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc("wrap1", 0, 0, 0, 0, 0);
        check_val("wrap_pc0", pc_o, 32'd0);
        check_val("wrap_pc4", ifid_pc4_o, 32'd0);
        cyc("wrap2", 0, 0, 0, 0, 0);
        check_val("wrap_pc4b", pc_o, 32'd4);

        // Misaligned redirect.
        cyc("mis", 0, 0, 0, 1, 32'h32);
`ifdef IF_MISALIGN_CHECK_EN
        check_val("mis_pc", pc_o, 32'h30);
        check_val("mis_flag", {31'd0, misalign_o}, 32'd1);
`else
        check_val("mis_pc", pc_o, 32'h32);
        check_val("mis_flag", {31'd0, misalign_o}, 32'd0);
`endif
        cyc("mis_after", 0, 0, 0, 0, 0);
        check_val("mis_clear", {31'd0, misalign_o}, 32'd0);

        // Randomized control traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r, s, f, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = {24'd0, rpc[7:0]};
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF8 | {30'd0, rpc[1:0]};
            cyc("rand", r, s, f, rd, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the RV32 pipeline. Holds the program counter and drives the combinational word-addressed instruction memory. Captures the fetched word into the IF/ID pipeline register. Handles hazard-unit stalls, IF/ID flushes and EX-stage branch/jump redirects, so that decode always sees either a valid instruction or a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on reset/flush/redirect
- clk_i  input  1  single clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- stall_i  input  1  hazard unit: hold PC and IF/ID contents
- flush_i  input  1  clear IF/ID to bubble; PC unaffected
- redirect_i  input  1  EX-stage taken branch/jump
- redirect_pc_i  input  32  redirect target
- imem_addr_o  output  32  instruction memory byte address (equals pc_o)
- imem_instr_i  input  32  combinational read data for imem_addr_o
- pc_o  output  32  current fetch PC
- ifid_pc_o  output  32  PC of instruction held in IF/ID
- ifid_pc4_o  output  32  ifid_pc_o + 4 (link value)
- ifid_instr_o  output  32  instruction held in IF/ID
- ifid_valid_o  output  1  IF/ID holds a real instruction
- misalign_o  output  1  misaligned redirect target flag (see Configuration)

## Operation
- State: pc register plus IF/ID register {pc, pc4, instr, valid}; misalign flag register.
- imem_addr_o = pc (combinational). Memory ignores bits [1:0].
- Per-edge priority, highest first:
  - rst_i: pc <= RESET_PC; IF/ID <= {0, 0, NOP_INSTR, 0}; misalign <= 0.
  - redirect_i: pc <= redirect_pc_i; IF/ID <= bubble. Overrides stall_i and flush_i.
  - flush_i: IF/ID <= bubble; pc <= pc if stall_i, else pc+4.
  - stall_i: pc and IF/ID hold.
  - normal: IF/ID <= {pc, pc+4, imem_instr_i, 1}; pc <= pc+4.
- Arithmetic: all PC sums are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Bubble contents: ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0.
- No FSM beyond reset / run; the stage is stateless other than the registers listed.

## Timing
- Reset values: pc_o=RESET_PC, imem_addr_o=RESET_PC, ifid_* = bubble, misalign_o=0.
- Fetch latency: one cycle. The word at pc appears on ifid_instr_o after the next rising edge.
- The first valid IF/ID word comes one edge after the first cycle with rst_i low.
- Redirect penalty: one bubble from this stage. The target instruction is valid in IF/ID two edges after redirect_i is sampled.
- Stall: outputs frozen for exactly the cycles stall_i is high. The first edge with stall_i low resumes normally.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge; no pending state survives.
- misalign_o is registered: high for exactly the one cycle after the offending redirect edge.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 loads pc <= {redirect_pc_i[31:2], 2'b00}.
  - misalign_o pulses high for one cycle.
  - The IF/ID bubble is inserted as for a normal redirect.
- Undefined:
  - pc loads redirect_pc_i unmodified.
  - misalign_o is tied 0.
  - The flag register is not built.

## Test plan
Memory preload: word0=00a00093, word1=00508113, word2=40510133, word11=00000013.
- Reset: rst_i high 2 cycles -> pc_o=0, ifid_valid_o=0, ifid_instr_o=00000013. After release: edge 1 gives ifid_instr_o=00a00093, ifid_pc_o=0, ifid_pc4_o=4, valid=1; edge 2 gives 00508113, pc 4.
- Stall: stall_i high 3 cycles while pc_o=8 -> pc_o stays 8, ifid_instr_o stays 00508113. The first edge after release gives 40510133, ifid_pc_o=8.
- Redirect to 0x2C -> next cycle pc_o=0x2C, ifid_valid_o=0, ifid_instr_o=00000013. Following edge gives ifid_pc_o=0x2C, valid=1.
- Redirect and stall_i high on the same edge to 0x2C -> pc_o=0x2C (redirect wins), IF/ID bubble. Flush and stall_i high together at pc 8 -> IF/ID bubble, pc_o stays 8.
- Wrap: redirect to 0xFFFF_FFFC, then run 2 edges -> pc_o=0, then 4. ifid_pc4_o=0 for the 0xFFFF_FFFC instruction.
- Misalign: redirect to 0x32 -> with IF_MISALIGN_CHECK_EN, pc_o=0x30 and misalign_o=1 for one cycle. Without the macro, pc_o=0x32 and misalign_o=0.
